fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controls the fetch stage for an instruction memory with variable latency and a request/valid handshake.
- Holds the fetch PC and issues one outstanding request at a time.
- Delivers the returned instruction with its PC and PC+4 to decode, and honours the decode stall.
- On a taken branch/jump redirect it discards in-flight or held instructions and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- MAX_WAIT, 15, cycles in WAIT/FLUSH without imem_valid before timeout (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- stall_d  in  1  decode cannot accept this cycle
- redirect  in  1  taken branch/jump resolved this cycle
- redirect_pc  in  32  target; bits [1:0] forced to 0 internally
- imem_req  out  1  request valid
- imem_addr  out  32  request address
- imem_ready  in  1  request accepted this cycle
- imem_valid  in  1  response data valid
- imem_rdata  in  32  response instruction
- instr_f  out  32  fetched instruction
- pc_f  out  32  PC of instr_f
- pc_plus4_f  out  32  pc_f + 4 (combinational, mod 2^32)
- instr_valid  out  1  instr_f is valid and not yet consumed
- stall_f  out  1  fetch not advancing this cycle
- imem_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock named clock; reset named reset, synchronous and active-high.
- Reset (on clock edge with reset=1), mid-operation included:
  - state=ISSUE, fetch_pc=RESET_PC.
  - instr_f=0, pc_f=0, instr_valid=0, imem_err=0, wait counter=0.
  - Any outstanding response is ignored; the memory is also reset by the system.
- Consume rule: the instruction is consumed in a cycle with instr_valid=1 and stall_d=0. Consumption clears instr_valid unless a new capture occurs in the same cycle.
- Redirect has highest priority in every state:
  - instr_valid<=0.
  - fetch_pc<=redirect_pc & ~3.
- Combinational outputs: imem_req=1 only in ISSUE; imem_addr=fetch_pc.
- stall_f = !(state==ISSUE && imem_ready).
- ISSUE:
  - Issue is gated: imem_req is held 0 while instr_valid=1 and stall_d=1. The single holding register must not overflow.
  - imem_ready=1 and no redirect -> WAIT, counter<=0.
  - Redirect with imem_ready=1 -> FLUSH (stale request already accepted).
  - Redirect with imem_ready=0 -> stay ISSUE at the new PC.
- WAIT:
  - imem_valid=1 and no redirect: instr_f<=imem_rdata, pc_f<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4.
  - Next state: HOLD if stall_d=1, else ISSUE.
  - Redirect with imem_valid=1 -> ISSUE (response dropped). Redirect without imem_valid -> FLUSH.
  - Counter increments on each cycle without imem_valid. On reaching MAX_WAIT: imem_err<=1 and -> ISSUE with fetch_pc unchanged (re-fetch).
- HOLD:
  - Outputs held.
  - stall_d=0 -> ISSUE; the instruction is consumed this cycle.
  - Redirect -> ISSUE.
- FLUSH:
  - imem_valid=1 -> discard data, -> ISSUE.
  - Redirect -> update fetch_pc, stay FLUSH.
  - Timeout is the same as in WAIT, -> ISSUE.
- Latency: minimum request-to-instr_valid is 2 cycles (ready in cycle n, valid in n+1, instr_valid visible in n+2). Best sustained throughput is one instruction every 2 cycles.
- Wrap-around: fetch_pc=32'hFFFF_FFFC increments to 0.
- Simultaneous events: imem_valid together with redirect resolves in favour of the redirect. imem_valid in ISSUE or HOLD is a protocol violation and is ignored.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles (32 bit), counting cycles with stall_f=1.
  - Adds output perf_redirects (16 bit), counting cycles with redirect=1.
  - Both counters saturate and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h100, imem responds 1 cycle after ready -> requests at 0x100, 0x104, 0x108. pc_f and instr_f match the responses, pc_plus4_f=pc_f+4, instr_valid pulses once per fetch.
- stall_d=1 for 4 cycles after capture of 0x104 -> state HOLD, instr_f and pc_f stable, imem_req=0. Next request is 0x108 only after stall_d falls.
- Redirect to 32'h0000_2003 during WAIT, response arrives 2 cycles later -> response discarded, instr_valid stays 0, next imem_addr=0x2000.
- Redirect in the same cycle as imem_valid -> data dropped, next state ISSUE at the target. Redirect while in HOLD -> instr_valid cleared the next cycle.
- imem never asserts valid, MAX_WAIT=15 -> imem_err=1 after 15 WAIT cycles, same address re-requested, imem_err remains set until reset.
- Reset asserted during WAIT -> next cycle instr_valid=0 and imem_addr=RESET_PC. With FETCH_SEQ_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus: one request in flight, accept on req&ready, data on valid.
// master = fetch side, slave = memory side.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_valid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding imem request, >=2 cycles request-to-instr_valid; issue is held off while decode stalls a valid instruction.
// Redirect flushes in-flight/held instructions; sticky timeout flag; FETCH_SEQ_PERF_EN adds saturating perf counters.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall_d,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   fetch_sequencer_if.master imem,
   output logic [31:0]       instr_f,
   output logic [31:0]       pc_f,
   output logic [31:0]       pc_plus4_f,
   output logic              instr_valid,
   output logic              stall_f,
   output logic              imem_err
`ifdef FETCH_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [15:0]       perf_redirects
`endif
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pcf_q, pcf_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;

   logic [31:0]   target_pc;
   logic [CW-1:0] wait_cnt_inc;
   logic          req;
   logic          accept;
   logic          consume;
   logic          timeout_hit;

   assign target_pc    = {redirect_pc[31:2], 2'b00};
   assign wait_cnt_inc = wait_cnt_q + CW'(1);
   assign timeout_hit  = (wait_cnt_inc == MAX_W);
   // Holding register is full and decode is stalled: a new request could overflow it.
   assign req          = (state_q == S_ISSUE) && !(valid_q && stall_d);
   assign accept       = req && imem.imem_ready;
   assign consume      = valid_q && !stall_d;

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;
   assign stall_f        = !accept;
   assign instr_f        = instr_q;
   assign pc_f           = pcf_q;
   assign pc_plus4_f     = pcf_q + 32'd4;
   assign instr_valid    = valid_q;
   assign imem_err       = err_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pcf_d      = pcf_q;
      valid_d    = valid_q && !consume;
      err_d      = err_q;
      wait_cnt_d = wait_cnt_q;

      unique case (state_q)
         S_ISSUE: begin
            if (accept) begin
               wait_cnt_d = '0;
               state_d    = redirect ? S_FLUSH : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_valid) begin
               if (!redirect) begin
                  instr_d    = imem.imem_rdata;
                  pcf_d      = fetch_pc_q;
                  valid_d    = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = stall_d ? S_HOLD : S_ISSUE;
               end else begin
                  state_d = S_ISSUE;
               end
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (timeout_hit) begin
                  err_d   = 1'b1;
                  state_d = S_ISSUE;
               end else if (redirect) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_HOLD: begin
            if (redirect || !stall_d) begin
               state_d = S_ISSUE;
            end
         end
         S_FLUSH: begin
            // The stale response drains the pipe; its data is never captured.
            if (imem.imem_valid) begin
               state_d = S_ISSUE;
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (timeout_hit) begin
                  err_d   = 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_ISSUE;
      endcase

      if (redirect) begin
         valid_d    = 1'b0;
         fetch_pc_d = target_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_ISSUE;
         fetch_pc_q <= RESET_PC;
         instr_q    <= '0;
         pcf_q      <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pcf_q      <= pcf_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef FETCH_SEQ_PERF_EN
   logic [31:0] perf_stall_q;
   logic [15:0] perf_redir_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_redir_q <= '0;
      end else begin
         if (stall_f && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (redirect && (perf_redir_q != '1)) begin
            perf_redir_q <= perf_redir_q + 16'd1;
         end
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_redirects    = perf_redir_q;
`endif

endmodule
